// File: rtl/add_sub_pkg.sv
// Shared constants for the single-precision add/sub datapath.
package add_sub_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned LZC_W  = $clog2(SIG_W + 1);

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

endpackage

// File: rtl/fp_normalize.sv
// Left-normalizes a significand by its leading-zero count and adjusts the exponent to match.
module fp_normalize
  import add_sub_pkg::*;
(
  input  logic        [SIG_W-1:0]  sig,
  input  logic        [EXP_W:0]    exp,
  output logic        [FRAC_W-1:0] frac,
  output logic signed [EXP_W+2:0]  exp_out,
  output logic                     is_zero
);

  logic [LZC_W-1:0] lzc;
  logic             found;
  logic [SIG_W-1:0] shifted;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (sig[i]) found = 1'b1;
        else        lzc   = lzc + 5'd1;
      end
    end
  end

  always_comb begin
    shifted = sig << lzc;
    frac    = shifted[FRAC_W-1:0];
    // After shifting, the top bit is set exactly when the input was non-zero.
    is_zero = ~shifted[SIG_W-1];
    exp_out = $signed({2'b00, exp}) - $signed({6'b000000, lzc});
  end

endmodule

// File: rtl/add_sub.sv
// Single-precision floating-point adder/subtractor, truncating, one registered output stage.
module add_sub
  import add_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sign,
  output logic [31:0] Result,
  output logic        Exception,
  output logic        zero
);

  logic [EXP_W-1:0] ea, eb, e_big, e_small, ediff;
  logic [SIG_W-1:0] siga, sigb, sig_big, sig_small, sig_small_sh, sig_pre;
  logic             sa, sb, a_big, s_big, special;
  logic [SIG_W:0]   sum;
  logic [EXP_W:0]   exp_pre;

  logic [FRAC_W-1:0]      n_frac;
  logic signed [EXP_W+2:0] n_exp;
  logic                   n_zero;

  logic [31:0] result_d;
  logic        exception_d, zero_d;

  // Denormals are flushed to zero: a zero exponent field drops the hidden bit too.
  always_comb begin
    ea      = A[30:23];
    eb      = B[30:23];
    siga    = (ea == '0) ? '0 : {1'b1, A[FRAC_W-1:0]};
    sigb    = (eb == '0) ? '0 : {1'b1, B[FRAC_W-1:0]};
    sa      = A[31];
    sb      = B[31] ^ sign;
    special = (ea == EXP_MAX) || (eb == EXP_MAX);

    a_big     = (ea > eb) || ((ea == eb) && (siga >= sigb));
    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    sig_big   = a_big ? siga : sigb;
    sig_small = a_big ? sigb : siga;
    s_big     = a_big ? sa : sb;
    ediff     = e_big - e_small;

    sig_small_sh = ({24'd0, ediff} >= SIG_W) ? '0 : (sig_small >> ediff);

    sum     = {1'b0, sig_big} + {1'b0, sig_small_sh};
    sig_pre = sig_big - sig_small_sh;
    exp_pre = {1'b0, e_big};
    if (sa == sb) begin
      if (sum[SIG_W]) begin
        sig_pre = sum[SIG_W:1];
        exp_pre = {1'b0, e_big} + 9'd1;
      end else begin
        sig_pre = sum[SIG_W-1:0];
      end
    end
  end

  fp_normalize u_norm (
    .sig     (sig_pre),
    .exp     (exp_pre),
    .frac    (n_frac),
    .exp_out (n_exp),
    .is_zero (n_zero)
  );

  always_comb begin
    result_d    = {s_big, n_exp[EXP_W-1:0], n_frac};
    exception_d = 1'b0;
    zero_d      = 1'b0;
    if (special) begin
      result_d    = QNAN;
      exception_d = 1'b1;
    end else if (n_zero || (n_exp <= 11'sd0)) begin
      result_d = '0;
      zero_d   = 1'b1;
    end else if (n_exp >= 11'sd255) begin
      result_d    = {s_big, EXP_MAX, 23'd0};
      exception_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Result    <= '0;
      Exception <= 1'b0;
      zero      <= 1'b0;
    end else begin
      Result    <= result_d;
      Exception <= exception_d;
      zero      <= zero_d;
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard bench for add_sub: driver queues hand-computed expectations, monitor checks them.
module tb_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic        sign;
  logic [31:0] Result;
  logic        Exception, zero;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exc;
    logic        zr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  add_sub dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .sign      (sign),
    .Result    (Result),
    .Exception (Exception),
    .zero      (zero)
  );

  task automatic apply(input string name, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic [31:0] er,
                       input logic ee, input logic ez);
    exp_t e;
    rst  = r;
    A    = a;
    B    = b;
    sign = s;
    e.name = name;
    e.res  = er;
    e.exc  = ee;
    e.zr   = ez;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are valid after every edge, so one expectation is retired per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Result !== e.res || Exception !== e.exc || zero !== e.zr) begin
          failures++;
          $display("FAIL %s: got Result=%h Exception=%b zero=%b, want Result=%h Exception=%b zero=%b",
                   e.name, Result, Exception, zero, e.res, e.exc, e.zr);
        end
      end
    end
  end

  initial begin
    int budget;
    apply("reset0", 1'b1, 32'h40500000, 32'hC0080000, 1'b1, 32'h0, 1'b0, 1'b0);
    apply("reset1", 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply("sub_3p25_m2p125", 1'b0, 32'h40500000, 32'hC0080000, 1'b1, 32'h40AC0000, 1'b0, 1'b0);
    apply("cancel_5p5", 1'b0, 32'h40B00000, 32'hC0B00000, 1'b0, 32'h00000000, 1'b0, 1'b1);
    apply("add_m3p26_1p28", 1'b0, 32'hC050A3D7, 32'h3FA3D70A, 1'b0, 32'hBFFD70A4, 1'b0, 1'b0);
    apply("inf_operand", 1'b0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0);
    apply("overflow_pos", 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    apply("overflow_neg", 1'b0, 32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0);
    apply("nan_b", 1'b0, 32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
    apply("both_zero", 1'b0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b1);
    apply("denorm_flush", 1'b0, 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    apply("shift_ge24", 1'b0, 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    apply("self_sub", 1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    apply("underflow", 1'b0, 32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    apply("sub_1p5_1", 1'b0, 32'h3FC00000, 32'hBF800000, 1'b0, 32'h3F000000, 1'b0, 1'b0);
    apply("neg_sum", 1'b0, 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 1'b0, 1'b0);
    apply("mid_reset", 1'b1, 32'h40500000, 32'hC0080000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    apply("after_reset", 1'b0, 32'h40500000, 32'hC0080000, 1'b1, 32'h40AC0000, 1'b0, 1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_sub.md
ADD_SUB -- requirements
Module: add_sub

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; port order: clk, rst, then data ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  32  IEEE-754 single-precision operand A.
REQ-005 B  input  32  IEEE-754 single-precision operand B.
REQ-006 sign  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 Result  output  32  registered single-precision result.
REQ-008 Exception  output  1  registered; 1 when the result is special or overflowed.
REQ-009 zero  output  1  registered; 1 when Result is +0 and Exception is 0.

Function
REQ-010 SHALL sample A, B and sign on every rising clk edge and present the corresponding Result, Exception and zero after that same edge (latency 1 cycle, throughput 1 per cycle, no handshake).
REQ-011 Effective B sign SHALL be B[31] XOR sign.
REQ-012 Operand with exponent field 0 SHALL be treated as zero (denormals flushed, sign ignored).
REQ-013 If either exponent field is 255: Exception=1, Result=32'h7FC00000, zero=0.
REQ-014 Hidden bit 1 SHALL be prepended to each non-zero fraction, giving 24-bit significands.
REQ-015 Larger-magnitude operand SHALL be chosen by exponent, then significand; result sign is its effective sign.
REQ-016 Smaller significand SHALL be right-shifted by the exponent difference and truncated to 24 bits; difference >= 24 contributes 0.
REQ-017 Equal effective signs SHALL add significands; a carry out shifts right 1 (truncating) and increments exponent.
REQ-018 Different effective signs SHALL subtract smaller from larger; result SHALL be left-normalized by leading-zero count, decrementing exponent.
REQ-019 Rounding SHALL be truncation (round toward zero); no guard/round/sticky bits.
REQ-020 Zero magnitude (including exact cancellation) SHALL give Result=32'h00000000, zero=1, Exception=0.
REQ-021 Exponent reaching 255 (overflow) SHALL give Exception=1, Result=signed infinity (sign,8'hFF,23'h0).
REQ-022 Exponent underflow (<=0 after normalization) SHALL give Result=32'h00000000, zero=1, Exception=0.
REQ-023 Both operands zero SHALL give +0, zero=1.

Reset
REQ-024 While rst=1 at a clk edge, Result SHALL become 32'h00000000, Exception 0, zero 0.
REQ-025 First edge with rst=0 SHALL capture a normal result from the then-present inputs; no other state exists.

Structure
REQ-026 A shared package SHALL hold constants: EXP_W=8, FRAC_W=23, SIG_W=24, EXP_MAX=8'hFF, QNAN=32'h7FC00000.
REQ-027 Datapath SHALL be combinational, feeding one output register stage.
REQ-028 One sub-module fp_normalize (leading-zero count plus left shift with exponent adjust) SHALL be used.

Verification
REQ-029 A=32'h40500000 (3.25), B=32'hC0080000 (-2.125), sign=1 -> Result=32'h40AC0000 (5.375), Exception=0, zero=0 one cycle later.
REQ-030 A=32'h40B00000 (5.5), B=32'hC0B00000 (-5.5), sign=0 -> Result=32'h00000000, zero=1, Exception=0.
REQ-031 A=32'hC050A3D7 (-3.26), B=32'h3FA3D70A (1.28), sign=0 -> Result=32'hBFFD70A4 (-1.98), Exception=0, zero=0.
REQ-032 A=32'h7F800000 (+inf), B=32'h3F800000, sign=0 -> Exception=1, Result=32'h7FC00000, zero=0.
REQ-033 A=B=32'h7F7FFFFF, sign=0 -> Exception=1, Result=32'h7F800000.
REQ-034 Assert rst for one edge mid-stream with valid inputs -> outputs 0,0,0 that cycle; next edge yields correct result.
